testcore_gpio_incap: RTL
========================

Name: testcore_gpio_incap

Overview:
- Input-conditioning and edge-capture stage downstream of the bidirectional GPIO pin block.
- Takes the raw 28-bit pin input vector, synchronises and debounces it, and latches selected rising/falling edges into a sticky capture register.
- Raises a level interrupt to the Nios II core and exposes filtered data and control over an Avalon-MM slave with 1-cycle read latency.

Parameters:
- WIDTH, 28, number of pin bits; 1..32.
- DIV, 1000, sample-tick prescaler period in clk cycles; >=2.
- STABLE, 3, consecutive equal samples required before a filtered bit changes; 2..7.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pin_in  in  WIDTH  raw pin levels from the GPIO block's data_in; asynchronous to clk.
- address  in  3  Avalon word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- filt_out  out  WIDTH  debounced pin state.
- irq  out  1  level interrupt.

Behaviour:
- Reset (synchronous, active-high, all sampled on rising clk):
  - sync FFs, filt_out, capture, irqmask, rise_en, fall_en, prescaler, per-bit counters and readdata all = 0; irq = 0.
- Synchroniser: 2-FF chain per bit (s1, s2). s2 is valid 2 cycles after a pin change.
- Prescaler: counts 0..DIV-1 and wraps. tick = 1 for one cycle when the count = DIV-1. The first tick occurs DIV cycles after reset release.
- Filter, per bit, evaluated only on tick:
  - if s2 != filt: cnt++; when cnt reaches STABLE-1 on a tick with s2 still != filt, filt <= s2 and cnt <= 0.
  - if s2 == filt: cnt <= 0.
  - Glitches shorter than STABLE ticks never reach filt_out.
- Edge detect uses the registered previous filt:
  - rise = filt & ~filt_d & rise_en
  - fall = ~filt & filt_d & fall_en
  - capture[i] <= 1 on rise[i] | fall[i].
- Capture clear: a write to address 2 clears capture bits where writedata = 1 (W1C). If set and clear hit the same bit in the same cycle, set wins.
- irq = |(capture & irqmask), registered: asserts 1 cycle after capture/mask update.
- Register map (word address; bits above WIDTH read 0, writes ignored):
  - 0 filt (RO)
  - 1 irqmask (RW)
  - 2 capture (R/W1C)
  - 3 rise_en (RW)
  - 4 fall_en (RW)
  - 5 raw s2 (RO)
  - 6..7 read 0
- Write accepted when chipselect & ~write_n. Writes to RO or unused addresses have no effect.
- Read: readdata <= mux(address) every cycle regardless of chipselect; valid the cycle after the address is presented. No side effect on read.
- Reset asserted mid-filter or mid-capture discards all state. No spurious edge is generated on release because filt and filt_d both reset to 0.
- Pins held high through reset: rise is captured once, after STABLE ticks.

Decomposition:
- Package testcore_gpio_pkg: register address constants (ADDR_FILT..ADDR_RAW) and default DIV/STABLE constants.
- One natural sub-module: testcore_gpio_debounce_bit (sync + counter + filt for one bit), instantiated WIDTH times with a shared tick.
- Prescaler, edge logic and the Avalon slave stay in the top.

Test Plan (DIV=4, STABLE=3 for sim):
1. Reset, then read all addresses -> readdata 0 for 0..7; irq 0; filt_out 0.
2. Write rise_en=0x1, irqmask=0x1; drive pin_in[0]=1 and hold -> filt_out[0] rises after 3 ticks (≈2+12 cycles); capture=0x1; irq=1 one cycle later.
3. Pulse pin_in[3]=1 for 2 ticks with rise_en[3]=1 -> filt_out[3] stays 0; capture[3] stays 0.
4. Capture=0x1: write 0x1 to address 2 -> capture=0, irq drops next cycle. Repeat with a clear write coinciding with a new edge on bit 0 -> capture[0] remains 1.
5. fall_en=0x0800_0000, irqmask=0; drive pin 27 high, then low (each held ≥3 ticks) -> capture=0x0800_0000, irq stays 0; then write irqmask=0x0800_0000 -> irq=1.
6. Assert reset while pin_in=0xFFFFFFF and after bits have filtered high -> all state 0. After release, filt=0xFFFFFFF after 3 ticks; capture = rise_en bits only.

Source files
------------

// File: rtl/testcore_gpio_pkg.sv
// testcore_gpio_pkg
//   Shared constants for the GPIO input-capture slice: Avalon word
//   addresses of the register map, default prescaler / debounce settings,
//   and the write-strobe decode used by the top.
package testcore_gpio_pkg;

  // Avalon word addresses (3-bit address bus).
  localparam logic [2:0] ADDR_FILT    = 3'd0;  // filtered pins, RO
  localparam logic [2:0] ADDR_IRQMASK = 3'd1;  // interrupt mask, RW
  localparam logic [2:0] ADDR_CAPTURE = 3'd2;  // sticky edge capture, R/W1C
  localparam logic [2:0] ADDR_RISE_EN = 3'd3;  // rising-edge enables, RW
  localparam logic [2:0] ADDR_FALL_EN = 3'd4;  // falling-edge enables, RW
  localparam logic [2:0] ADDR_RAW     = 3'd5;  // synchronised raw pins, RO

  localparam int DEF_WIDTH  = 28;
  localparam int DEF_DIV    = 1000;
  localparam int DEF_STABLE = 3;

  // One-hot write strobes for the writable registers.
  typedef struct packed {
    logic irqmask;
    logic capture;
    logic rise_en;
    logic fall_en;
  } wr_dec_t;

  // Decode an accepted write to its target register; RO and unused
  // addresses produce no strobe.
  function automatic wr_dec_t decode_wr(input logic [2:0] addr, input logic en);
    wr_dec_t d;
    d         = '0;
    d.irqmask = en && (addr == ADDR_IRQMASK);
    d.capture = en && (addr == ADDR_CAPTURE);
    d.rise_en = en && (addr == ADDR_RISE_EN);
    d.fall_en = en && (addr == ADDR_FALL_EN);
    return d;
  endfunction

endpackage

// File: rtl/testcore_gpio_debounce_bit.sv
// testcore_gpio_debounce_bit
//   One pin lane: 2-FF synchroniser followed by a tick-sampled debounce
//   counter. The filtered level only follows the synchronised level after
//   STABLE consecutive ticks on which they disagree.
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   tick        shared sample strobe from the prescaler
//   pin         raw asynchronous pin level
//   raw         synchronised level (s2)
//   filt        debounced level
module testcore_gpio_debounce_bit #(
  parameter int STABLE = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic pin,
  output logic raw,
  output logic filt
);

  localparam int CW = $clog2(STABLE);

  logic          s1;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b0;
      raw  <= 1'b0;
      filt <= 1'b0;
      cnt  <= '0;
    end else begin
      s1  <= pin;
      raw <= s1;
      if (tick) begin
        if (raw != filt) begin
          // Third (STABLE-th) disagreeing tick commits the new level.
          if (cnt == CW'(STABLE - 1)) begin
            filt <= raw;
            cnt  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          // Any agreeing tick restarts the run, so short glitches die here.
          cnt <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/testcore_gpio_incap.sv
// testcore_gpio_incap
//   Input conditioning and edge capture behind the GPIO pin block.
//   Pins are synchronised and debounced per bit, selected rising/falling
//   edges of the filtered level set sticky capture bits, and a masked OR of
//   the capture register drives a level interrupt. Registers are reached
//   over an Avalon-MM slave with one cycle of read latency.
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   pin_in[WIDTH]        raw pin levels (asynchronous)
//   address[3]           Avalon word address
//   chipselect, write_n  write accepted when chipselect & ~write_n
//   writedata[32]        write data
//   readdata[32]         registered read data (address of previous cycle)
//   filt_out[WIDTH]      debounced pin state
//   irq                  level interrupt, |(capture & irqmask), registered
module testcore_gpio_incap
  import testcore_gpio_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIV    = DEF_DIV,
  parameter int STABLE = DEF_STABLE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] filt_out,
  output logic             irq
);

  localparam int PW = $clog2(DIV);

  // Zero-extend a pin-width vector onto the 32-bit data bus.
  function automatic logic [31:0] zx(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r            = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // Sample prescaler: tick on the last count of each DIV-cycle period, so
  // the first tick lands DIV cycles after reset release.
  // ---------------------------------------------------------------------
  logic [PW-1:0] pcnt;
  logic          tick;

  assign tick = (pcnt == PW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset)     pcnt <= '0;
    else if (tick) pcnt <= '0;
    else           pcnt <= pcnt + 1'b1;
  end

  // ---------------------------------------------------------------------
  // Per-bit synchroniser + debounce, one lane per pin, shared tick.
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] raw;

  testcore_gpio_debounce_bit #(
    .STABLE (STABLE)
  ) u_db [WIDTH-1:0] (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .pin   (pin_in),
    .raw   (raw),
    .filt  (filt_out)
  );

  // ---------------------------------------------------------------------
  // Edge detect and control registers.
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] filt_d;
  logic [WIDTH-1:0] capture;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] clr;
  wr_dec_t          wdec;
  logic             unused_wdata;

  // Bits of writedata above WIDTH have no destination.
  assign unused_wdata = ^writedata;

  assign wdata = writedata[WIDTH-1:0];
  assign wdec  = decode_wr(address, chipselect & ~write_n);
  assign clr   = wdec.capture ? wdata : '0;

  // filt and filt_d both reset low, so leaving reset never fakes an edge.
  assign rise  =  filt_out & ~filt_d & rise_en;
  assign fall  = ~filt_out &  filt_d & fall_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_d  <= '0;
      capture <= '0;
      irqmask <= '0;
      rise_en <= '0;
      fall_en <= '0;
      irq     <= 1'b0;
    end else begin
      filt_d  <= filt_out;
      // Clear first, then OR in new edges: a simultaneous set wins.
      capture <= (capture & ~clr) | rise | fall;
      irq     <= |(capture & irqmask);
      if (wdec.irqmask) irqmask <= wdata;
      if (wdec.rise_en) rise_en <= wdata;
      if (wdec.fall_en) fall_en <= wdata;
    end
  end

  // ---------------------------------------------------------------------
  // Read path: registered every cycle regardless of chipselect; reads
  // have no side effects.
  // ---------------------------------------------------------------------
  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_FILT:    rd_mux = zx(filt_out);
      ADDR_IRQMASK: rd_mux = zx(irqmask);
      ADDR_CAPTURE: rd_mux = zx(capture);
      ADDR_RISE_EN: rd_mux = zx(rise_en);
      ADDR_FALL_EN: rd_mux = zx(fall_en);
      ADDR_RAW:     rd_mux = zx(raw);
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_mux;
  end

endmodule
